// File: rtl/kanagawa_hal_reset_pkg.sv
// Shared types and parameter-legality limits for the staged reset sequencer.
package kanagawa_hal_reset_pkg;

    typedef enum logic [1:0] {
        RSEQ_HOLD    = 2'd0,
        RSEQ_STRETCH = 2'd1,
        RSEQ_RELEASE = 2'd2,
        RSEQ_RUN     = 2'd3
    } reset_seq_state_t;

    localparam int RSEQ_MIN_STAGES = 1;
    localparam int RSEQ_MAX_STAGES = 32;
    localparam int RSEQ_MIN_CYCLES = 1;

    function automatic int rseq_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/kanagawa_hal_reset_sequencer.sv
// Staged reset release: filters clock lock, stretches reset, then frees
// NUM_STAGES domains in order, stage 0 first. Lock loss or soft reset re-enters HOLD.
module kanagawa_hal_reset_sequencer
    import kanagawa_hal_reset_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int LOCK_FILTER    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  locked_in,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  rst_done
);

    localparam int CNT_MAX = rseq_max3(LOCK_FILTER, STRETCH_CYCLES, STAGE_GAP);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(NUM_STAGES + 1);

    if (NUM_STAGES < RSEQ_MIN_STAGES || NUM_STAGES > RSEQ_MAX_STAGES) begin : g_bad_stages
        $error("kanagawa_hal_reset_sequencer: NUM_STAGES out of range");
    end
    if (LOCK_FILTER < RSEQ_MIN_CYCLES) begin : g_bad_filter
        $error("kanagawa_hal_reset_sequencer: LOCK_FILTER must be >= 1");
    end
    if (STRETCH_CYCLES < RSEQ_MIN_CYCLES) begin : g_bad_stretch
        $error("kanagawa_hal_reset_sequencer: STRETCH_CYCLES must be >= 1");
    end
    if (STAGE_GAP < RSEQ_MIN_CYCLES) begin : g_bad_gap
        $error("kanagawa_hal_reset_sequencer: STAGE_GAP must be >= 1");
    end

    reset_seq_state_t      state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_out_d;
    logic                  done_d;
    logic                  all_rst;
    logic                  abort;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= RSEQ_HOLD;
            cnt_q    <= '0;
            stage_q  <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            rst_out  <= rst_out_d;
            rst_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        all_rst = 1'b0;
        done_d  = 1'b0;
        abort   = ~locked_in | soft_rst_req;

        // Abort is tested before every expiry so it always wins a tie.
        case (state_q)
            RSEQ_HOLD: begin
                all_rst = 1'b1;
                stage_d = '0;
                if (abort) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(LOCK_FILTER)) begin
                    state_d = RSEQ_STRETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSEQ_STRETCH: begin
                all_rst = 1'b1;
                if (abort) begin
                    state_d = RSEQ_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
                    state_d = RSEQ_RELEASE;
                    cnt_d   = '0;
                    stage_d = '0;
                    all_rst = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSEQ_RELEASE: begin
                if (abort) begin
                    state_d = RSEQ_HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    all_rst = 1'b1;
                end else if (stage_q == SW'(NUM_STAGES - 1)) begin
                    state_d = RSEQ_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    stage_d = stage_q + 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RSEQ_RUN: begin
                if (abort) begin
                    state_d = RSEQ_HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    all_rst = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = RSEQ_HOLD;
                cnt_d   = '0;
                stage_d = '0;
                all_rst = 1'b1;
            end
        endcase

        // Stages above the current index stay in reset; this keeps release ordered.
        for (int k = 0; k < NUM_STAGES; k++) begin
            rst_out_d[k] = all_rst | (k > int'(stage_d));
        end
    end

endmodule

// File: tb/tb_kanagawa_hal_reset_sequencer.sv
// Directed bench: default-parameter sequencer plus a NUM_STAGES=1 corner instance.
module tb_kanagawa_hal_reset_sequencer;

    logic       clk;
    logic       arst, locked_in, soft_rst_req;
    logic [3:0] rst_out;
    logic       rst_done;

    logic       c_arst, c_locked, c_soft;
    logic [0:0] c_rst_out;
    logic       c_done;

    int n_chk  = 0;
    int n_pass = 0;

    int         rel_e [4];
    int         done_e;
    logic [3:0] ab_rst;
    logic       ab_done;
    bit         order_ok;

    kanagawa_hal_reset_sequencer dut (
        .clk          (clk),
        .arst         (arst),
        .locked_in    (locked_in),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out),
        .rst_done     (rst_done)
    );

    kanagawa_hal_reset_sequencer #(
        .NUM_STAGES     (1),
        .LOCK_FILTER    (1),
        .STRETCH_CYCLES (1),
        .STAGE_GAP      (1)
    ) dut_c (
        .clk          (clk),
        .arst         (c_arst),
        .locked_in    (c_locked),
        .soft_rst_req (c_soft),
        .rst_out      (c_rst_out),
        .rst_done     (c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Hold arst, then release it at a negedge so the next posedge is edge 0.
    task automatic start_seq();
        arst         = 1'b1;
        locked_in    = 1'b1;
        soft_rst_req = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        arst = 1'b0;
    endtask

    // Run n edges; record the last 1->0 edge of each stage and last 0->1 of done.
    task automatic observe(input int n, input int lo_e, input int soft_e, input int ab_e);
        logic [3:0] prev;
        logic       prev_done;
        prev      = rst_out;
        prev_done = rst_done;
        for (int k = 0; k < 4; k++) rel_e[k] = -1;
        done_e   = -1;
        order_ok = 1'b1;
        ab_rst   = 4'h0;
        ab_done  = 1'b1;
        for (int e = 0; e < n; e++) begin
            locked_in    = (e != lo_e);
            soft_rst_req = (e == soft_e);
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (prev[k] && !rst_out[k]) rel_e[k] = e;
                if (k > 0 && rst_out[k-1] && !rst_out[k]) order_ok = 1'b0;
            end
            if (!prev_done && rst_done) done_e = e;
            if (e == ab_e) begin
                ab_rst  = rst_out;
                ab_done = rst_done;
            end
            prev      = rst_out;
            prev_done = rst_done;
        end
        locked_in    = 1'b1;
        soft_rst_req = 1'b0;
    endtask

    initial begin
        arst = 1'b1; locked_in = 1'b1; soft_rst_req = 1'b0;
        c_arst = 1'b1; c_locked = 1'b1; c_soft = 1'b0;
        #2;
        chk("reset_rst_out", rst_out, 4'hF);
        chk("reset_done", rst_done, 0);

        // Default power-up
        start_seq();
        observe(50, -1, -1, -1);
        chk("pwr_rel0", rel_e[0], 20);
        chk("pwr_rel1", rel_e[1], 28);
        chk("pwr_rel2", rel_e[2], 36);
        chk("pwr_rel3", rel_e[3], 44);
        chk("pwr_done", done_e, 45);
        chk("pwr_order", order_ok, 1);
        chk("pwr_run_out", rst_out, 4'h0);

        // Lock bounce at edge 3
        start_seq();
        observe(30, 3, -1, -1);
        chk("bounce_rel0", rel_e[0], 24);

        // Soft reset while in HOLD restarts the filter
        start_seq();
        observe(30, -1, 2, -1);
        chk("hold_soft_rel0", rel_e[0], 23);

        // Runtime lock loss in RUN at edge 50
        start_seq();
        observe(100, 50, -1, 50);
        chk("lockloss_ab_rst", ab_rst, 4'hF);
        chk("lockloss_ab_done", ab_done, 0);
        chk("lockloss_rel0", rel_e[0], 71);
        chk("lockloss_rel3", rel_e[3], 95);
        chk("lockloss_done", done_e, 96);

        // Soft reset mid-RELEASE after stage 1 freed
        start_seq();
        observe(80, -1, 30, 30);
        chk("softrel_ab_rst", ab_rst, 4'hF);
        chk("softrel_ab_done", ab_done, 0);
        chk("softrel_rel0", rel_e[0], 51);
        chk("softrel_rel1", rel_e[1], 59);
        chk("softrel_done", done_e, 76);
        chk("softrel_order", order_ok, 1);

        // Async reset mid-STRETCH
        start_seq();
        observe(10, -1, -1, -1);
        #3;
        arst = 1'b1;
        #1;
        chk("async_rst_out", rst_out, 4'hF);
        chk("async_done", rst_done, 0);
        @(negedge clk);
        arst = 1'b0;
        observe(25, -1, -1, -1);
        chk("async_restart_rel0", rel_e[0], 20);

        // Corner instance: all parameters 1
        @(negedge clk);
        c_arst = 1'b0;
        @(posedge clk); #1;
        chk("c_e0_rst", c_rst_out, 1);
        @(posedge clk); #1;
        chk("c_e1_rst", c_rst_out, 1);
        @(posedge clk); #1;
        chk("c_e2_rst", c_rst_out, 0);
        chk("c_e2_done", c_done, 0);
        @(posedge clk); #1;
        chk("c_e3_done", c_done, 1);

        // Abort coincident with stretch expiry resolves to HOLD
        c_arst = 1'b1;
        #1;
        @(negedge clk);
        c_arst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        c_locked = 1'b0;
        @(posedge clk); #1;
        chk("c_tie_rst", c_rst_out, 1);
        c_locked = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("c_retry_e4_rst", c_rst_out, 1);
        @(posedge clk); #1;
        chk("c_retry_e5_rst", c_rst_out, 0);
        c_soft = 1'b1;
        @(posedge clk); #1;
        chk("c_soft_rst", c_rst_out, 1);
        chk("c_soft_done", c_done, 0);
        c_soft = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
